bit_recover_rx: RTL and testbench
=================================

BIT_RECOVER_RX -- requirements
Module: bit_recover_rx

Interface
REQ-001 SHALL have parameter SYNC_WORD, 16'hEB90, frame sync pattern, MSB first.
REQ-002 SHALL have parameter LOCK_RUN, 16, consecutive alternating decided bits required for lock.
REQ-003 SHALL have parameter ADJ_SHIFT, 3, timing correction step = i_sample_FTW >> ADJ_SHIFT.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port i_sample_FTW  input  32  NCO tuning word for the symbol rate, static during operation.
REQ-007 SHALL have port i_rx_bit  input  1  asynchronous hard-decision serial line.
REQ-008 SHALL have port o_bit_valid  output  1  one-cycle strobe; o_bit_data holds a payload bit.
REQ-009 SHALL have port o_bit_data  output  1  payload bit, MSB first per byte.
REQ-010 SHALL have port o_frame_len  output  8  payload byte count of the current frame.
REQ-011 SHALL have port o_locked  output  1  preamble lock indicator.
REQ-012 SHALL have port o_rx_end_pulse  output  1  one-cycle pulse when the last payload bit has been issued.

Function
REQ-013 SHALL pass i_rx_bit through a 2-flop synchronizer; an edge is declared when the synchronized value differs from its previous-cycle value.
REQ-014 SHALL run a 32-bit phase accumulator advancing by i_sample_FTW per cycle, wrapping modulo 2^32.
REQ-015 SHALL raise a sample strobe in the cycle phase bit 31 changes 0->1 between consecutive cycles, sampling the synchronized bit.
REQ-016 On an edge with phase[31]=0, SHALL subtract the correction step after the increment, saturating at 0.
REQ-017 On an edge with phase[31]=1, SHALL add the correction step after the increment, saturating at 2^32-1.
REQ-018 If the increment wraps in the same cycle as an edge, SHALL apply no correction that cycle.
REQ-019 Corrections SHALL never produce zero or two sample strobes within one symbol period.
REQ-020 SHALL count consecutive sampled bits differing from their predecessor; o_locked SHALL set when the count reaches LOCK_RUN.
REQ-021 SHALL have states HUNT, LEN, DATA.
REQ-022 HUNT: shift sampled bits into a 16-bit register; when o_locked=1 and the register equals SYNC_WORD, go to LEN.
REQ-023 A sync match with o_locked=0 SHALL be ignored.
REQ-024 LEN: collect 8 bits MSB first into o_frame_len; if the value is 0, pulse o_rx_end_pulse and return to HUNT; otherwise go to DATA.
REQ-025 DATA: each sample SHALL produce o_bit_valid=1 for one cycle, one cycle after the strobe, with o_bit_data = the sampled bit.
REQ-026 DATA SHALL issue exactly 8*o_frame_len bits.
REQ-027 o_rx_end_pulse SHALL be asserted in the same cycle as the last o_bit_valid, then the block SHALL enter HUNT.
REQ-028 On end of frame, o_locked SHALL clear, the lock counter and sync register SHALL clear, and o_frame_len SHALL hold its value.
REQ-029 o_bit_valid SHALL never be asserted outside DATA.

Reset
REQ-030 On rst, SHALL set phase=0, synchronizer=0, state=HUNT, counters=0, and o_bit_valid, o_bit_data, o_frame_len, o_locked, o_rx_end_pulse all to 0.
REQ-031 rst asserted mid-frame SHALL abort the frame with no o_rx_end_pulse.

Structure
REQ-032 Package rx_pkg SHALL hold the state encoding and the SYNC_WORD and LOCK_RUN defaults.
REQ-033 The phase accumulator with correction and strobe generation SHALL be sub-module rx_nco; framing stays in bit_recover_rx.

Verification
REQ-034 FTW=2^32/16; 40 alternating symbols, then sync EB90, length 8'h02, payload A5 3C -> o_locked=1; 16 valid bits 1010010100111100; one end pulse on the 16th.
REQ-035 Same frame with length 8'h00 -> end pulse after the length byte; zero o_bit_valid.
REQ-036 Only 8 alternating symbols, then EB90 -> o_locked stays 0; no LEN entry.
REQ-037 TX 1% slower than FTW, 250-byte payload -> all 2000 bits correct; exactly one strobe per symbol.
REQ-038 rst pulse after 5 payload bits -> outputs 0 next cycle; no end pulse; the next full frame decodes correctly.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared state encoding and default framing parameters for the serial bit-recovery receiver.
package rx_pkg;
  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2
  } rx_state_e;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hEB90;
  localparam int unsigned LOCK_RUN_DEF  = 16;
  localparam int unsigned ADJ_SHIFT_DEF = 3;
endpackage

// File: rtl/rx_nco.sv
// Symbol timing recovery: 2-flop input synchronizer, phase accumulator with
// edge-driven bang-bang correction, and a mid-symbol sample strobe.
module rx_nco #(
  parameter int unsigned ADJ_SHIFT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ftw,
  input  logic        rx_async,
  output logic        strobe,
  output logic        sample
);
  logic        sync1, sync2, sync_prev;
  logic [31:0] phase, phase_n, step;
  logic        msb_prev, edge_det;
  logic [32:0] inc, boost;

  always_comb begin
    inc      = {1'b0, phase} + {1'b0, ftw};
    step     = ftw >> ADJ_SHIFT;
    boost    = {1'b0, inc[31:0]} + {1'b0, step};
    edge_det = sync2 ^ sync_prev;
    phase_n  = inc[31:0];
    // Edge in the low half: NCO is early, retard. High half: NCO is late, advance.
    // A wrap in the same cycle already realigns, so no correction then.
    if (edge_det && !inc[32]) begin
      if (!phase[31]) phase_n = (inc[31:0] >= step) ? inc[31:0] - step : '0;
      else            phase_n = boost[32] ? '1 : boost[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b0;
      sync2     <= 1'b0;
      sync_prev <= 1'b0;
      phase     <= '0;
      msb_prev  <= 1'b0;
    end else begin
      sync1     <= rx_async;
      sync2     <= sync1;
      sync_prev <= sync2;
      phase     <= phase_n;
      msb_prev  <= phase[31];
    end
  end

  assign strobe = phase[31] & ~msb_prev;
  assign sample = sync2;
endmodule

// File: rtl/bit_recover_rx.sv
// Serial bit recovery receiver: preamble lock, sync-word hunt, length byte and
// payload bit delivery on top of the rx_nco sample strobe.
module bit_recover_rx
  import rx_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int unsigned LOCK_RUN  = LOCK_RUN_DEF,
  parameter int unsigned ADJ_SHIFT = ADJ_SHIFT_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_sample_FTW,
  input  logic        i_rx_bit,
  output logic        o_bit_valid,
  output logic        o_bit_data,
  output logic [7:0]  o_frame_len,
  output logic        o_locked,
  output logic        o_rx_end_pulse
);
  localparam int unsigned RUN_W = $clog2(LOCK_RUN + 1);

  rx_state_e        state, state_n;
  logic             strobe, sample;
  logic             last_bit;
  logic [RUN_W-1:0] run_cnt;
  logic [14:0]      sync_sr;
  logic [15:0]      sync_next;
  logic [6:0]       len_sr;
  logic [7:0]       len_val;
  logic [10:0]      bit_cnt, total_m1;
  logic             valid_n, end_n, frame_done, len_load;

  rx_nco #(.ADJ_SHIFT(ADJ_SHIFT)) u_nco (
    .clk      (clk),
    .rst      (rst),
    .ftw      (i_sample_FTW),
    .rx_async (i_rx_bit),
    .strobe   (strobe),
    .sample   (sample)
  );

  // sync_sr keeps 15 bits of history; the 16-bit window includes the bit being sampled.
  assign sync_next = {sync_sr, sample};
  assign len_val   = {len_sr, sample};
  assign total_m1  = {o_frame_len, 3'b000} - 11'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= HUNT;
    else     state <= state_n;
  end

  always_comb begin
    state_n    = state;
    valid_n    = 1'b0;
    end_n      = 1'b0;
    frame_done = 1'b0;
    len_load   = 1'b0;
    case (state)
      HUNT: if (strobe && o_locked && sync_next == SYNC_WORD) state_n = LEN;
      LEN: if (strobe && bit_cnt == 11'd7) begin
        len_load = 1'b1;
        if (len_val == 8'd0) begin
          end_n      = 1'b1;
          frame_done = 1'b1;
          state_n    = HUNT;
        end else begin
          state_n = DATA;
        end
      end
      DATA: if (strobe) begin
        valid_n = 1'b1;
        if (bit_cnt == total_m1) begin
          end_n      = 1'b1;
          frame_done = 1'b1;
          state_n    = HUNT;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_bit_valid    <= 1'b0;
      o_bit_data     <= 1'b0;
      o_frame_len    <= '0;
      o_locked       <= 1'b0;
      o_rx_end_pulse <= 1'b0;
      last_bit       <= 1'b0;
      run_cnt        <= '0;
      sync_sr        <= '0;
      len_sr         <= '0;
      bit_cnt        <= '0;
    end else begin
      o_bit_valid    <= valid_n;
      o_rx_end_pulse <= end_n;
      if (valid_n) o_bit_data <= sample;

      if (state_n != state)                bit_cnt <= '0;
      else if (strobe && state != HUNT)    bit_cnt <= bit_cnt + 11'd1;

      if (strobe) begin
        last_bit <= sample;
        sync_sr  <= sync_next[14:0];
        if (state == LEN) len_sr <= {len_sr[5:0], sample};
        if (sample != last_bit) begin
          if (run_cnt != RUN_W'(LOCK_RUN))     run_cnt  <= run_cnt + RUN_W'(1);
          if (run_cnt == RUN_W'(LOCK_RUN - 1)) o_locked <= 1'b1;
        end else begin
          run_cnt <= '0;
        end
      end

      if (len_load) o_frame_len <= len_val;

      if (frame_done) begin
        o_locked <= 1'b0;
        run_cnt  <= '0;
        sync_sr  <= '0;
      end
    end
  end
endmodule

// File: tb/tb_bit_recover_rx.sv
// Self-checking bench for bit_recover_rx: framed serial stimulus against a
// payload/lock reference model, including rate offset and mid-frame reset.
module tb_bit_recover_rx;
  localparam logic [15:0] SYNC     = 16'hEB90;
  localparam int          LOCK_RUN = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ftw = 32'h1000_0000;
  logic        rx_line = 1'b0;
  logic        o_bit_valid, o_bit_data, o_locked, o_rx_end_pulse;
  logic [7:0]  o_frame_len;

  int checks = 0;
  int passed = 0;
  int sym_t  = 1600;
  logic [7:0] pay [0:255];

  bit rx_q[$];
  int end_cnt     = 0;
  int end_at      = -1;
  int lock_cycles = 0;

  always #50 clk = ~clk;

  bit_recover_rx #(
    .SYNC_WORD (SYNC),
    .LOCK_RUN  (LOCK_RUN),
    .ADJ_SHIFT (3)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_sample_FTW   (ftw),
    .i_rx_bit       (rx_line),
    .o_bit_valid    (o_bit_valid),
    .o_bit_data     (o_bit_data),
    .o_frame_len    (o_frame_len),
    .o_locked       (o_locked),
    .o_rx_end_pulse (o_rx_end_pulse)
  );

  always @(negedge clk) begin
    if (o_bit_valid) rx_q.push_back(o_bit_data);
    if (o_rx_end_pulse) begin
      end_cnt = end_cnt + 1;
      end_at  = rx_q.size();
    end
    if (o_locked) lock_cycles = lock_cycles + 1;
  end

  task automatic tx(input logic b);
    rx_line = b;
    #(sym_t);
  endtask

  task automatic send_frame(input int npre, input logic [7:0] len, input int npay);
    logic [15:0] sw = SYNC;
    repeat (4) tx(1'b0);
    for (int k = 0; k < npre; k++) tx((k % 2) == 0);
    for (int k = 15; k >= 0; k--) tx(sw[k]);
    for (int k = 7; k >= 0; k--) tx(len[k]);
    for (int b = 0; b < npay; b++)
      for (int k = 7; k >= 0; k--) tx(pay[b][k]);
    repeat (4) tx(1'b0);
    repeat (10) @(negedge clk);
  endtask

  // Lock rule: LOCK_RUN consecutive sampled bits differing from their
  // predecessor (idle 0 precedes the preamble) must complete before the last sync bit.
  function automatic bit model_detect(input int npre);
    bit seq[$];
    int run;
    bit lk;
    logic [15:0] sw = SYNC;
    seq.push_back(1'b0);
    for (int k = 0; k < npre; k++) seq.push_back((k % 2) == 0);
    for (int k = 15; k >= 0; k--) seq.push_back(sw[k]);
    run = 0;
    lk  = 1'b0;
    for (int i = 1; i < seq.size() - 1; i++) begin
      run = (seq[i] != seq[i-1]) ? run + 1 : 0;
      if (run >= LOCK_RUN) lk = 1'b1;
    end
    return lk;
  endfunction

  function automatic int count_errs(input int qb, input int nbits);
    int errs = 0;
    for (int i = 0; i < nbits; i++)
      if (qb + i >= rx_q.size() || rx_q[qb + i] != pay[i / 8][7 - (i % 8)]) errs++;
    return errs;
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({o_bit_valid, o_bit_data, o_locked, o_rx_end_pulse} !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", {o_bit_valid, o_bit_data, o_locked, o_rx_end_pulse});
    else passed++;
    checks++;
    if (o_frame_len !== 8'h00) $display("FAIL reset_len: got %h expected 00", o_frame_len);
    else passed++;
    rst = 1'b0;
  endtask

  task automatic test_basic_frame;
    int qb, eb, lb, nv;
    logic [15:0] got;
    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    qb = rx_q.size(); eb = end_cnt; lb = lock_cycles;
    send_frame(40, 8'h02, 2);
    nv = rx_q.size() - qb;
    for (int i = 0; i < 16; i++) got[15 - i] = (qb + i < rx_q.size()) ? rx_q[qb + i] : 1'bx;
    checks++;
    if (nv !== 16) $display("FAIL basic_count: got %0d expected 16", nv); else passed++;
    checks++;
    if (got !== {pay[0], pay[1]}) $display("FAIL basic_bits: got %b expected %b", got, {pay[0], pay[1]});
    else passed++;
    checks++;
    if (end_cnt - eb !== 1) $display("FAIL basic_end_count: got %0d expected 1", end_cnt - eb); else passed++;
    checks++;
    if (end_at - qb !== 16) $display("FAIL basic_end_pos: got %0d expected 16", end_at - qb); else passed++;
    checks++;
    if ((lock_cycles - lb > 0) !== 1'b1) $display("FAIL basic_locked: got %0d locked cycles expected >0", lock_cycles - lb);
    else passed++;
    checks++;
    if (o_locked !== 1'b0) $display("FAIL basic_unlock: got %b expected 0", o_locked); else passed++;
    checks++;
    if (o_frame_len !== 8'h02) $display("FAIL basic_len_hold: got %h expected 02", o_frame_len); else passed++;
  endtask

  task automatic test_zero_len;
    int qb, eb;
    qb = rx_q.size(); eb = end_cnt;
    send_frame(40, 8'h00, 2);
    checks++;
    if (rx_q.size() - qb !== 0) $display("FAIL zero_valids: got %0d expected 0", rx_q.size() - qb); else passed++;
    checks++;
    if (end_cnt - eb !== 1) $display("FAIL zero_end_count: got %0d expected 1", end_cnt - eb); else passed++;
    checks++;
    if (end_at - qb !== 0) $display("FAIL zero_end_pos: got %0d expected 0", end_at - qb); else passed++;
    checks++;
    if (o_frame_len !== 8'h00) $display("FAIL zero_len: got %h expected 00", o_frame_len); else passed++;
  endtask

  task automatic test_no_lock;
    int qb, eb, lb, exp_bits, exp_ends;
    bit det;
    logic [7:0] len_before, exp_len;
    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    det = model_detect(8);
    exp_bits = det ? 16 : 0;
    exp_ends = det ? 1 : 0;
    len_before = o_frame_len;
    exp_len = det ? 8'h02 : len_before;
    qb = rx_q.size(); eb = end_cnt; lb = lock_cycles;
    send_frame(8, 8'h02, 2);
    checks++;
    if (lock_cycles - lb !== (det ? lock_cycles - lb : 0))
      $display("FAIL nolock_locked: got %0d locked cycles expected 0", lock_cycles - lb);
    else passed++;
    checks++;
    if (rx_q.size() - qb !== exp_bits) $display("FAIL nolock_valids: got %0d expected %0d", rx_q.size() - qb, exp_bits);
    else passed++;
    checks++;
    if (end_cnt - eb !== exp_ends) $display("FAIL nolock_end: got %0d expected %0d", end_cnt - eb, exp_ends);
    else passed++;
    checks++;
    if (o_frame_len !== exp_len) $display("FAIL nolock_len: got %h expected %h", o_frame_len, exp_len); else passed++;
  endtask

  task automatic test_random_frames;
    int qb, eb, npre, nbits, errs;
    logic [7:0] len;
    bit det;
    for (int f = 0; f < 4; f++) begin
      len  = 8'($urandom_range(0, 6));
      npre = $urandom_range(24, 48);
      for (int b = 0; b < 6; b++) pay[b] = 8'($urandom);
      det   = model_detect(npre);
      nbits = det ? 8 * len : 0;
      qb = rx_q.size(); eb = end_cnt;
      send_frame(npre, len, int'(len));
      errs = count_errs(qb, nbits);
      checks++;
      if (rx_q.size() - qb !== nbits) $display("FAIL rand%0d_count: got %0d expected %0d", f, rx_q.size() - qb, nbits);
      else passed++;
      checks++;
      if (errs !== 0) $display("FAIL rand%0d_bits: got %0d wrong bits expected 0", f, errs); else passed++;
      checks++;
      if (end_cnt - eb !== (det ? 1 : 0)) $display("FAIL rand%0d_end: got %0d expected %0d", f, end_cnt - eb, det ? 1 : 0);
      else passed++;
      checks++;
      if (det && o_frame_len !== len) $display("FAIL rand%0d_len: got %h expected %h", f, o_frame_len, len);
      else passed++;
    end
  endtask

  task automatic test_drift;
    int qb, eb, errs;
    rst = 1'b1;
    ftw = 32'h4000_0000;
    sym_t = 404;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int b = 0; b < 250; b++) pay[b] = 8'($urandom);
    qb = rx_q.size(); eb = end_cnt;
    send_frame(40, 8'd250, 250);
    errs = count_errs(qb, 2000);
    checks++;
    if (rx_q.size() - qb !== 2000) $display("FAIL drift_count: got %0d expected 2000", rx_q.size() - qb); else passed++;
    checks++;
    if (errs !== 0) $display("FAIL drift_bits: got %0d wrong bits expected 0", errs); else passed++;
    checks++;
    if (end_cnt - eb !== 1) $display("FAIL drift_end_count: got %0d expected 1", end_cnt - eb); else passed++;
    checks++;
    if (end_at - qb !== 2000) $display("FAIL drift_end_pos: got %0d expected 2000", end_at - qb); else passed++;
  endtask

  task automatic test_reset_midframe;
    int qb, eb, errs;
    rst = 1'b1;
    ftw = 32'h1000_0000;
    sym_t = 1600;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    pay[0] = 8'hA5;
    pay[1] = 8'h3C;
    qb = rx_q.size(); eb = end_cnt;
    fork
      send_frame(40, 8'h02, 2);
      begin
        int n = 0;
        while (rx_q.size() - qb < 5 && n < 20000) begin
          @(negedge clk);
          n++;
        end
        checks++;
        if (rx_q.size() - qb !== 5) $display("FAIL midrst_reach5: got %0d bits expected 5", rx_q.size() - qb);
        else passed++;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_bit_valid, o_bit_data, o_locked, o_rx_end_pulse, o_frame_len} !== 12'h000)
          $display("FAIL midrst_outputs: got %h expected 000",
                   {o_bit_valid, o_bit_data, o_locked, o_rx_end_pulse, o_frame_len});
        else passed++;
        rst = 1'b0;
      end
    join
    checks++;
    if (end_cnt - eb !== 0) $display("FAIL midrst_no_end: got %0d expected 0", end_cnt - eb); else passed++;
    checks++;
    if (rx_q.size() - qb !== 5) $display("FAIL midrst_aborted: got %0d bits expected 5", rx_q.size() - qb); else passed++;

    pay[0] = 8'($urandom);
    pay[1] = 8'($urandom);
    qb = rx_q.size(); eb = end_cnt;
    send_frame(40, 8'h02, 2);
    errs = count_errs(qb, 16);
    checks++;
    if (rx_q.size() - qb !== 16) $display("FAIL midrst_next_count: got %0d expected 16", rx_q.size() - qb); else passed++;
    checks++;
    if (errs !== 0) $display("FAIL midrst_next_bits: got %0d wrong bits expected 0", errs); else passed++;
    checks++;
    if (end_cnt - eb !== 1) $display("FAIL midrst_next_end: got %0d expected 1", end_cnt - eb); else passed++;
  endtask

  initial begin
    test_reset;
    test_basic_frame;
    test_zero_len;
    test_no_lock;
    test_random_frames;
    test_drift;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
